// File: rtl/ysyx_22050854_imm_enc_if.sv
// Request/response bus of the immediate encoder.
// slave  : the encoder's view (takes requests, produces results)
// master : the requester/consumer view
interface ysyx_22050854_imm_enc_if;
    // Request side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base;
    logic [2:0]  ExtOP;
    logic [63:0] imm;
    // Result side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        out_err;

    modport slave (
        input  in_valid,
        input  base,
        input  ExtOP,
        input  imm,
        input  out_ready,
        output in_ready,
        output out_valid,
        output instr,
        output out_err
    );

    modport master (
        output in_valid,
        output base,
        output ExtOP,
        output imm,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  instr,
        input  out_err
    );
endinterface

// File: rtl/ysyx_22050854_imm_enc.sv
// Immediate encoder: inserts a signed immediate into the immediate fields of
// a RISC-V instruction template, flagging values the format cannot hold.
// Two-stage elastic pipeline:
//   stage 1 holds the request and its range-check result,
//   stage 2 holds the encoded instruction and the error flag.
// Optional: define IMM_ENC_ERRCNT_EN to add a saturating 16-bit err_cnt output
// counting transfers that carried out_err=1.
module ysyx_22050854_imm_enc (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_22050854_imm_enc_if.slave      bus
`ifdef IMM_ENC_ERRCNT_EN
    ,
    output logic [15:0]                 err_cnt
`endif
);

    // Immediate format codes
    localparam logic [2:0] OpI      = 3'b000;
    localparam logic [2:0] OpU      = 3'b001;
    localparam logic [2:0] OpS      = 3'b010;
    localparam logic [2:0] OpB      = 3'b011;
    localparam logic [2:0] OpJ      = 3'b100;
    localparam logic [2:0] OpCoushu = 3'b101;

    // Stage 1 state
    logic        s1_valid_q;
    logic [31:0] s1_base_q;
    logic [2:0]  s1_op_q;
    logic [31:0] s1_imm_q;   // bits above 31 are only needed for the range check
    logic        s1_err_q;

    // Stage 2 state
    logic        s2_valid_q;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;

    // Handshake
    logic        s2_load_ok;
    logic        s1_load_ok;
    logic        in_fire;
    logic        out_fire;

    // Range check / encoding
    logic        sext_ok_11;
    logic        sext_ok_12;
    logic        sext_ok_20;
    logic        sext_ok_31;
    logic        range_err;
    logic [31:0] enc_instr;

    // A stage may load when it is empty or its contents leave this cycle.
    // in_ready therefore depends only on stage state and out_ready.
    assign s2_load_ok = !s2_valid_q || bus.out_ready;
    assign s1_load_ok = !s1_valid_q || s2_load_ok;

    assign in_fire    = bus.in_valid && s1_load_ok;
    assign out_fire   = s2_valid_q && bus.out_ready;

    assign bus.in_ready  = s1_load_ok;
    assign bus.out_valid = s2_valid_q;
    assign bus.instr     = s2_instr_q;
    assign bus.out_err   = s2_err_q;

    // imm fits in N+1 signed bits when imm[63:N] is a pure sign extension
    assign sext_ok_11 = (&bus.imm[63:11]) || !(|bus.imm[63:11]);
    assign sext_ok_12 = (&bus.imm[63:12]) || !(|bus.imm[63:12]);
    assign sext_ok_20 = (&bus.imm[63:20]) || !(|bus.imm[63:20]);
    assign sext_ok_31 = (&bus.imm[63:31]) || !(|bus.imm[63:31]);

    // Range check of the incoming request; illegal formats always error
    always_comb begin
        range_err = 1'b1;
        case (bus.ExtOP)
            OpI, OpS: range_err = !sext_ok_11;
            OpU:      range_err = (|bus.imm[11:0]) || !sext_ok_31;
            OpB:      range_err = bus.imm[0] || !sext_ok_12;
            OpJ:      range_err = bus.imm[0] || !sext_ok_20;
            OpCoushu: range_err = |bus.imm[63:7];
            default:  range_err = 1'b1;
        endcase
    end

    // Stage 1 register: request plus range-check result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_base_q  <= 32'h0;
            s1_op_q    <= 3'b000;
            s1_imm_q   <= 32'h0;
            s1_err_q   <= 1'b0;
        end else if (s1_load_ok) begin
            s1_valid_q <= bus.in_valid;
            if (in_fire) begin
                s1_base_q <= bus.base;
                s1_op_q   <= bus.ExtOP;
                s1_imm_q  <= bus.imm[31:0];
                s1_err_q  <= range_err;
            end
        end
    end

    // Overwrite only the immediate fields of the template; truncation is
    // applied even when the range check failed
    always_comb begin
        enc_instr = s1_base_q;
        case (s1_op_q)
            OpI: begin
                enc_instr[31:20] = s1_imm_q[11:0];
            end
            OpU: begin
                enc_instr[31:12] = s1_imm_q[31:12];
            end
            OpS: begin
                enc_instr[31:25] = s1_imm_q[11:5];
                enc_instr[11:7]  = s1_imm_q[4:0];
            end
            OpB: begin
                enc_instr[31]    = s1_imm_q[12];
                enc_instr[7]     = s1_imm_q[11];
                enc_instr[30:25] = s1_imm_q[10:5];
                enc_instr[11:8]  = s1_imm_q[4:1];
            end
            OpJ: begin
                enc_instr[31]    = s1_imm_q[20];
                enc_instr[19:12] = s1_imm_q[19:12];
                enc_instr[20]    = s1_imm_q[11];
                enc_instr[30:21] = s1_imm_q[10:1];
            end
            OpCoushu: begin
                enc_instr[6:0]   = s1_imm_q[6:0];
            end
            default: begin
                enc_instr = s1_base_q;
            end
        endcase
    end

    // Stage 2 register: encoded result, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'h0;
            s2_err_q   <= 1'b0;
        end else if (s2_load_ok) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= enc_instr;
                s2_err_q   <= s1_err_q;
            end
        end
    end

`ifdef IMM_ENC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Count errored transfers, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0;
        end else if (out_fire && s2_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Only the optional counter consumes the transfer strobe
    logic unused_out_fire;
    assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_ysyx_22050854_imm_enc.sv
// Bench for the immediate encoder: directed vectors with literal expectations,
// a reference model of the encoding rules and a per-cycle scoreboard compare.
// Define IMM_ENC_ERRCNT_EN to also exercise the error counter.
module tb_ysyx_22050854_imm_enc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef IMM_ENC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    ysyx_22050854_imm_enc_if bus ();

    ysyx_22050854_imm_enc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IMM_ENC_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int m_errcnt = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model from the format rules: range as signed bounds,
    // encoding as a field mask over the template. Returns {err, instr}.
    function automatic logic [32:0] model(input logic [31:0] b, input logic [2:0] op,
                                          input logic [63:0] imm);
        longint     s;
        logic       err;
        logic [31:0] m;
        logic [31:0] f;
        s = imm;
        err = 1'b1;
        m = 32'h0;
        f = 32'h0;
        case (op)
            3'd0: begin
                err = !(s >= -2048 && s <= 2047);
                m = 32'hFFF0_0000;
                f = {imm[11:0], 20'b0};
            end
            3'd1: begin
                err = (imm[11:0] != 12'h0) || !(s >= -64'sh8000_0000 && s <= 64'sh7FFF_FFFF);
                m = 32'hFFFF_F000;
                f = {imm[31:12], 12'b0};
            end
            3'd2: begin
                err = !(s >= -2048 && s <= 2047);
                m = 32'hFE00_0F80;
                f = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            end
            3'd3: begin
                err = imm[0] || !(s >= -4096 && s <= 4095);
                m = 32'hFE00_0F80;
                f = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            end
            3'd4: begin
                err = imm[0] || !(s >= -64'sh10_0000 && s <= 64'shF_FFFF);
                m = 32'hFFFF_F000;
                f = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            end
            3'd5: begin
                err = imm > 64'd127;
                m = 32'h0000_007F;
                f = {25'b0, imm[6:0]};
            end
            default: begin
                err = 1'b1;
            end
        endcase
        return {err, (b & ~m) | (f & m)};
    endfunction

    // Scoreboard: inputs change only at posedge+1, so negedge values are
    // the values seen at the following active edge
    logic        hold_v = 1'b0;
    logic [32:0] hold_val;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 1'b0;
            m_errcnt = 0;
        end else begin
`ifdef IMM_ENC_ERRCNT_EN
            chk("err_cnt_track", {48'h0, err_cnt}, 64'(m_errcnt));
`endif
            if (hold_v) begin
                chk("hold_valid", {63'h0, bus.out_valid}, 64'h1);
                chk("hold_stable", {31'h0, bus.out_err, bus.instr}, {31'h0, hold_val});
            end
            hold_v = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                chk("out_expected", {63'h0, exp_q.size() != 0}, 64'h1);
                if (exp_q.size() != 0) begin
                    chk("out_data", {31'h0, bus.out_err, bus.instr}, {31'h0, exp_q[0]});
                    if (exp_q[0][32] && m_errcnt < 65535) m_errcnt++;
                    void'(exp_q.pop_front());
                end
                n_out++;
            end else if (bus.out_valid) begin
                hold_v = 1'b1;
                hold_val = {bus.out_err, bus.instr};
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.base, bus.ExtOP, bus.imm));
        end
    end

    // Present one request at posedge+1 and hold it until accepted (bounded)
    task automatic send_one(input logic [31:0] b, input logic [2:0] op, input logic [63:0] imm);
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.base = b;
        bus.ExtOP = op;
        bus.imm = imm;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'h0, 64'h1);
        bus.in_valid = 1'b0;
    endtask

    // Idle pipeline, out_ready=1: result must show up exactly two edges later
    task automatic check_direct(input string name, input logic [31:0] b, input logic [2:0] op,
                                input logic [63:0] imm, input logic [31:0] ei,
                                input logic ee);
        bus.out_ready = 1'b1;
        send_one(b, op, imm);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, {63'h0, bus.out_valid}, 64'h1);
        chk({name, "_instr"}, {32'h0, bus.instr}, {32'h0, ei});
        chk({name, "_err"}, {63'h0, bus.out_err}, {63'h0, ee});
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(name, {63'h0, k < 50}, 64'h1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int out0;
        logic [63:0] v;
        bus.in_valid = 1'b0;
        bus.base = 32'h0;
        bus.ExtOP = 3'b000;
        bus.imm = 64'h0;
        bus.out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_instr", {32'h0, bus.instr}, 64'h0);
        chk("rst_out_err", {63'h0, bus.out_err}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);

        // Pin the model against hand-computed encodings
        chk("model_i", {31'h0, model(32'h13, 3'd0, -64'sd1)}, {31'h0, 1'b0, 32'hFFF0_0013});
        chk("model_b", {31'h0, model(32'h63, 3'd3, 64'd4094)}, {31'h0, 1'b0, 32'h7E00_0FE3});
        chk("model_u", {31'h0, model(32'h37, 3'd1, 64'h1234_5001)}, {31'h0, 1'b1, 32'h1234_5037});

        // Directed end-to-end vectors
        check_direct("i_neg1",   32'h0000_0013, 3'd0, -64'sd1,        32'hFFF0_0013, 1'b0);
        check_direct("b_4094",   32'h0000_0063, 3'd3, 64'd4094,       32'h7E00_0FE3, 1'b0);
        check_direct("b_odd",    32'h0000_0063, 3'd3, 64'd3,          32'h0000_0163, 1'b1);
        check_direct("u_ok",     32'h0000_0037, 3'd1, 64'h1234_5000,  32'h1234_5037, 1'b0);
        check_direct("u_low",    32'h0000_0037, 3'd1, 64'h1234_5001,  32'h1234_5037, 1'b1);
        check_direct("j_2048",   32'h0000_006F, 3'd4, 64'd2048,       32'h0010_006F, 1'b0);
        check_direct("s_neg4",   32'h0000_2023, 3'd2, -64'sd4,        32'hFE00_2E23, 1'b0);
        check_direct("c_55",     32'hFFFF_FFFF, 3'd5, 64'h55,         32'hFFFF_FFD5, 1'b0);
        check_direct("c_128",    32'hFFFF_FFFF, 3'd5, 64'd128,        32'hFFFF_FF80, 1'b1);
        check_direct("illegal6", 32'h1234_5678, 3'd6, 64'd0,          32'h1234_5678, 1'b1);
        check_direct("i_2047",   32'h0000_0013, 3'd0, 64'd2047,       32'h7FF0_0013, 1'b0);
        check_direct("i_2048",   32'h0000_0013, 3'd0, 64'd2048,       32'h8000_0013, 1'b1);
        check_direct("i_m2048",  32'h0000_0013, 3'd0, -64'sd2048,     32'h8000_0013, 1'b0);
        drain("drain_direct");

        // Backpressure: two accepted, third stalled, then same-cycle refill
        out0 = n_out;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.base = 32'h13;
        bus.ExtOP = 3'd0;
        bus.imm = 64'd1;
        @(negedge clk);
        chk("bp_acc1", {63'h0, bus.in_ready}, 64'h1);
        @(posedge clk);
        #1;
        bus.imm = 64'd2;
        @(negedge clk);
        chk("bp_acc2", {63'h0, bus.in_ready}, 64'h1);
        @(posedge clk);
        #1;
        bus.imm = 64'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_full_ready", {63'h0, bus.in_ready}, 64'h0);
            chk("bp_full_valid", {63'h0, bus.out_valid}, 64'h1);
            chk("bp_head", {32'h0, bus.instr}, 64'h0010_0013);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_refill_ready", {63'h0, bus.in_ready}, 64'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain("drain_bp");
        chk("bp_count", 64'(n_out - out0), 64'd3);

        // Random traffic with random consumer stalls
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            case ($urandom_range(0, 3))
                0: v = 64'(longint'(int'($urandom_range(0, 8191))) - 4096);
                1: v = 64'(longint'(int'($urandom_range(0, 4194303))) - 2097152);
                2: v = {$urandom, $urandom};
                default: v = 64'(longint'(int'($urandom))) & ~64'hFFF;
            endcase
            if (!bus.in_valid || bus.in_ready) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.base = $urandom;
                bus.ExtOP = 3'($urandom_range(0, 7));
                bus.imm = v;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain("drain_rand");

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send_one(32'h13, 3'd0, 64'd5);
        send_one(32'h13, 3'd0, 64'd6);
        chk("rf_full", {63'h0, bus.out_valid}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rf_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rf_instr", {32'h0, bus.instr}, 64'h0);
        chk("rf_out_err", {63'h0, bus.out_err}, 64'h0);
`ifdef IMM_ENC_ERRCNT_EN
        chk("rf_err_cnt", {48'h0, err_cnt}, 64'h0);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rf_no_stale", {63'h0, bus.out_valid}, 64'h0);
        end
        chk("rf_in_ready", {63'h0, bus.in_ready}, 64'h1);

`ifdef IMM_ENC_ERRCNT_EN
        // Three errored plus two clean transfers
        send_one(32'h0, 3'd6, 64'd0);
        send_one(32'h13, 3'd0, 64'd1);
        send_one(32'h13, 3'd0, 64'd4096);
        send_one(32'h37, 3'd1, 64'h1000);
        send_one(32'h0, 3'd7, 64'd0);
        drain("drain_errcnt");
        chk("errcnt_3", {48'h0, err_cnt}, 64'd3);
        // Stream errors up to the saturation point, then one more
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.ExtOP = 3'd6;
        repeat (65532) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain("drain_sat");
        chk("errcnt_ffff", {48'h0, err_cnt}, 64'hFFFF);
        send_one(32'h0, 3'd6, 64'd0);
        drain("drain_sat1");
        chk("errcnt_sat", {48'h0, err_cnt}, 64'hFFFF);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_imm_enc.md
YSYX_22050854_IMM_ENC -- requirements
Module: ysyx_22050854_imm_enc

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, request valid.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high at a rising edge.
REQ-005 SHALL have port base, input, 32, instruction template; its non-immediate fields are kept.
REQ-006 SHALL have port ExtOP, input, 3, immediate format: 000 I, 001 U, 010 S, 011 B, 100 J, 101 Coushu (raw bits 6:0).
REQ-007 SHALL have port imm, input, 64, signed immediate value to insert.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, consumer ready; transfer when out_valid and out_ready are both high.
REQ-010 SHALL have port instr, output, 32, encoded instruction.
REQ-011 SHALL have port out_err, output, 1, imm not representable in the format, or ExtOP illegal.

Function
REQ-012 SHALL overwrite only the format's immediate bit positions of base: I [31:20]=imm[11:0]; U [31:12]=imm[31:12]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; J [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]; Coushu [6:0]=imm[6:0].
REQ-013 SHALL set out_err when: I/S: imm[63:11] not all equal; U: imm[11:0]!=0 or imm[63:31] not all equal; B: imm[0]!=0 or imm[63:12] not all equal; J: imm[0]!=0 or imm[63:20] not all equal; Coushu: imm[63:7]!=0.
REQ-014 SHALL, for ExtOP 110/111, pass base unchanged and set out_err=1.
REQ-015 SHALL still produce the truncated encoding of REQ-012 when out_err=1.
REQ-016 SHALL be a two-stage elastic pipeline: stage 1 registers the request plus the range-check result; stage 2 registers the encoded instr and out_err.
REQ-017 SHALL have a latency of exactly 2 cycles from acceptance to out_valid with no backpressure, and sustain one transaction per cycle.
REQ-018 SHALL let each stage load when it is empty or its contents move forward in the same cycle.
REQ-019 SHALL derive in_ready combinationally from stage state and out_ready, with no combinational path from in_valid to in_ready.
REQ-020 SHALL hold instr and out_err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL never drop, duplicate or reorder transactions; with both stages full and out_ready=0, in_ready=0.
REQ-022 SHALL, when full, accept a new request in the same cycle that out_ready drains stage 2.

Reset
REQ-023 SHALL on rst_n low immediately clear both stage valid flags: out_valid=0, instr=32'h0, out_err=0, in_ready=1 after release.
REQ-024 SHALL discard in-flight transactions when reset is asserted mid-operation; no output for them appears after release.

Configuration
REQ-025 SHALL, when IMM_ENC_ERRCNT_EN is defined, add output err_cnt, 16 bits, reset to 0: +1 per transfer with out_err=1, saturating at 16'hFFFF.
REQ-026 SHALL, when IMM_ENC_ERRCNT_EN is undefined, omit err_cnt and its logic; all other behaviour is identical.

Verification
REQ-027 I-type: base=32'h00000013, ExtOP=000, imm=-1, out_ready=1 -> 2 cycles later instr=32'hFFF00013, out_err=0.
REQ-028 B-type: base=32'h00000063, ExtOP=011, imm=4094 -> instr=32'h7E000FE3, out_err=0; imm=3 -> out_err=1.
REQ-029 U-type: base=32'h00000037, ExtOP=001, imm=32'h12345000 -> instr=32'h12345037, out_err=0; imm=32'h12345001 -> out_err=1.
REQ-030 Backpressure: out_ready=0, 3 back-to-back requests -> 2 accepted, in_ready=0 on the third; raise out_ready -> all 3 emerge in order, none lost.
REQ-031 Reset: pulse rst_n low with both stages full -> out_valid=0 at once; no stale output after release; err_cnt=0 when enabled.
REQ-032 Error counter (IMM_ENC_ERRCNT_EN): 3 errored plus 2 clean transfers -> err_cnt=3; pre-load at 16'hFFFF plus one error -> stays 16'hFFFF.
